// File: rtl/mem_read_seq_if.sv
// Bundles the block-read control, source-memory bus and downstream staging handshake.
// The sequencer drives through the master modport; the environment uses slave.
interface mem_read_seq_if #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 4
);
    logic          start;
    logic [AW-1:0] src_addr;
    logic [AW:0]   length;
    logic [DW-1:0] MemData;
    logic          ready;
    logic [AW-1:0] MemAddr;
    logic          MemRd;
    logic [DW-1:0] DOut1;
    logic          valid;
    logic          busy;
    logic          done;

    modport master (
        input  start, src_addr, length, MemData, ready,
        output MemAddr, MemRd, DOut1, valid, busy, done
    );

    modport slave (
        output start, src_addr, length, MemData, ready,
        input  MemAddr, MemRd, DOut1, valid, busy, done
    );
endinterface

// File: rtl/mem_read_seq.sv
// Block-read sequencer: reads 'length' words from a source memory starting at src_addr and
// presents each one on DOut1 until the downstream staging register accepts it.
module mem_read_seq #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 4
) (
    input logic            clock,
    input logic            reset_n,
    mem_read_seq_if.master bus
);
    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StRead = 3'd1;
    localparam logic [2:0] StWait = 3'd2;
    localparam logic [2:0] StHold = 3'd3;
    localparam logic [2:0] StDone = 3'd4;

    localparam logic [AW:0]   CntOne  = 1;
    localparam logic [AW-1:0] AddrOne = 1;

    logic          rst_sync_q;
    logic [2:0]    state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [DW-1:0] dout_q, dout_d;

    // Assert asynchronously, release on a clock edge so no state moves on a partial cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) rst_sync_q <= 1'b0;
        else          rst_sync_q <= 1'b1;
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    addr_d  = bus.src_addr;
                    cnt_d   = bus.length;
                    state_d = (bus.length == '0) ? StDone : StRead;
                end
            end
            StRead: state_d = StWait;
            StWait: begin
                dout_d  = bus.MemData;
                state_d = StHold;
            end
            StHold: begin
                if (bus.ready) begin
                    cnt_d   = cnt_q - CntOne;
                    addr_d  = addr_q + AddrOne; // wraps modulo 2^AW
                    state_d = (cnt_q == CntOne) ? StDone : StRead;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            state_q <= StIdle;
            addr_q  <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
        end
    end

    assign bus.MemRd   = (state_q == StRead);
    assign bus.MemAddr = addr_q;
    assign bus.DOut1   = dout_q;
    assign bus.valid   = (state_q == StHold);
    assign bus.busy    = (state_q != StIdle);
    assign bus.done    = (state_q == StDone);
endmodule

// File: tb/tb_mem_read_seq.sv
// Directed bench for mem_read_seq: source memory holds 8'hA2 + address at every location.
// flags = {MemRd, valid, busy, done}, sampled 1 time unit after each rising edge.
module tb_mem_read_seq;
    logic clock;
    logic reset_n;
    int   total;
    int   bad;

    mem_read_seq_if #(.DW(8), .AW(4)) bus ();

    mem_read_seq #(.DW(8), .AW(4)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Source memory: data appears the cycle after a read strobe.
    always @(posedge clock) begin
        if (bus.MemRd) bus.MemData <= 8'hA2 + {4'h0, bus.MemAddr};
    end

    logic [3:0] flags;
    assign flags = {bus.MemRd, bus.valid, bus.busy, bus.done};

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.start = 1'b0;
        bus.ready = 1'b0;
        bus.src_addr = 4'h0;
        bus.length = 5'd0;
        #3;
        total++;
        if (flags !== 4'b0000) begin
            bad++; $display("FAIL reset flags got=%b exp=0000", flags);
        end
        total++;
        if (bus.MemAddr !== 4'h0 || bus.DOut1 !== 8'h00) begin
            bad++; $display("FAIL reset addr/data got=%h/%h exp=0/00", bus.MemAddr, bus.DOut1);
        end
        bus.start = 1'b1;
        tick();
        tick();
        total++;
        if (flags !== 4'b0000) begin
            bad++; $display("FAIL reset start_ignored flags got=%b exp=0000", flags);
        end
        reset_n = 1'b1;
        tick();
        total++;
        if (flags !== 4'b0000) begin
            bad++; $display("FAIL reset sync_release flags got=%b exp=0000", flags);
        end
        tick();
        bus.start = 1'b0;
        total++;
        if (flags !== 4'b0011) begin
            bad++; $display("FAIL reset first_start flags got=%b exp=0011", flags);
        end
        tick();
        total++;
        if (flags !== 4'b0000) begin
            bad++; $display("FAIL reset back_idle flags got=%b exp=0000", flags);
        end
    endtask

    task automatic test_single();
        bus.src_addr = 4'h3;
        bus.length = 5'd1;
        bus.ready = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        total++;
        if (flags !== 4'b1010 || bus.MemAddr !== 4'h3) begin
            bad++; $display("FAIL single c1 flags/addr got=%b/%h exp=1010/3", flags, bus.MemAddr);
        end
        tick();
        total++;
        if (flags !== 4'b0010) begin
            bad++; $display("FAIL single c2 flags got=%b exp=0010", flags);
        end
        tick();
        total++;
        if (flags !== 4'b0110 || bus.DOut1 !== 8'hA5) begin
            bad++; $display("FAIL single c3 flags/data got=%b/%h exp=0110/a5", flags, bus.DOut1);
        end
        tick();
        total++;
        if (flags !== 4'b0011) begin
            bad++; $display("FAIL single c4 flags got=%b exp=0011", flags);
        end
        tick();
        total++;
        if (flags !== 4'b0000) begin
            bad++; $display("FAIL single c5 flags got=%b exp=0000", flags);
        end
    endtask

    task automatic test_backpressure();
        bus.src_addr = 4'h5;
        bus.length = 5'd2;
        bus.ready = 1'b1; // ready while valid=0 must be ignored
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        total++;
        if (flags !== 4'b1010 || bus.MemAddr !== 4'h5) begin
            bad++; $display("FAIL bp c1 flags/addr got=%b/%h exp=1010/5", flags, bus.MemAddr);
        end
        tick();
        bus.ready = 1'b0;
        total++;
        if (flags !== 4'b0010) begin
            bad++; $display("FAIL bp c2 flags got=%b exp=0010", flags);
        end
        tick();
        for (int i = 0; i < 5; i++) begin
            total++;
            if (flags !== 4'b0110 || bus.DOut1 !== 8'hA7) begin
                bad++;
                $display("FAIL bp stall%0d flags/data got=%b/%h exp=0110/a7", i, flags, bus.DOut1);
            end
            tick();
        end
        total++;
        if (flags !== 4'b0110 || bus.DOut1 !== 8'hA7) begin
            bad++; $display("FAIL bp stall_end flags/data got=%b/%h exp=0110/a7", flags, bus.DOut1);
        end
        bus.ready = 1'b1;
        tick();
        total++;
        if (flags !== 4'b1010 || bus.MemAddr !== 4'h6) begin
            bad++; $display("FAIL bp resume flags/addr got=%b/%h exp=1010/6", flags, bus.MemAddr);
        end
        tick();
        tick();
        total++;
        if (flags !== 4'b0110 || bus.DOut1 !== 8'hA8) begin
            bad++; $display("FAIL bp word2 flags/data got=%b/%h exp=0110/a8", flags, bus.DOut1);
        end
        tick();
        total++;
        if (flags !== 4'b0011) begin
            bad++; $display("FAIL bp done flags got=%b exp=0011", flags);
        end
        tick();
    endtask

    task automatic test_wrap();
        logic [3:0] a;
        logic [7:0] d;
        bus.src_addr = 4'hE;
        bus.length = 5'd4;
        bus.ready = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int w = 0; w < 4; w++) begin
            a = 4'(14 + w);
            d = 8'hA2 + {4'h0, a};
            total++;
            if (flags !== 4'b1010 || bus.MemAddr !== a) begin
                bad++;
                $display("FAIL wrap rd%0d flags/addr got=%b/%h exp=1010/%h", w, flags, bus.MemAddr, a);
            end
            tick();
            total++;
            if (flags !== 4'b0010) begin
                bad++; $display("FAIL wrap wait%0d flags got=%b exp=0010", w, flags);
            end
            tick();
            total++;
            if (flags !== 4'b0110 || bus.DOut1 !== d) begin
                bad++;
                $display("FAIL wrap hold%0d flags/data got=%b/%h exp=0110/%h", w, flags, bus.DOut1, d);
            end
            tick();
        end
        total++;
        if (flags !== 4'b0011) begin
            bad++; $display("FAIL wrap done flags got=%b exp=0011", flags);
        end
        tick();
        total++;
        if (flags !== 4'b0000) begin
            bad++; $display("FAIL wrap idle flags got=%b exp=0000", flags);
        end
    endtask

    task automatic test_zero_length();
        bus.src_addr = 4'h4;
        bus.length = 5'd0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        total++;
        if (flags !== 4'b0011) begin
            bad++; $display("FAIL zero c1 flags got=%b exp=0011", flags);
        end
        tick();
        total++;
        if (flags !== 4'b0000) begin
            bad++; $display("FAIL zero c2 flags got=%b exp=0000", flags);
        end
    endtask

    task automatic test_back_to_back();
        bus.length = 5'd0;
        bus.start = 1'b1;
        bus.ready = 1'b1;
        tick();
        bus.src_addr = 4'h7;
        bus.length = 5'd1;
        total++;
        if (flags !== 4'b0011) begin
            bad++; $display("FAIL b2b done1 flags got=%b exp=0011", flags);
        end
        tick();
        total++;
        if (flags !== 4'b0000) begin
            bad++; $display("FAIL b2b idle flags got=%b exp=0000", flags);
        end
        tick();
        bus.start = 1'b0;
        total++;
        if (flags !== 4'b1010 || bus.MemAddr !== 4'h7) begin
            bad++; $display("FAIL b2b rd flags/addr got=%b/%h exp=1010/7", flags, bus.MemAddr);
        end
        tick();
        tick();
        total++;
        if (flags !== 4'b0110 || bus.DOut1 !== 8'hA9) begin
            bad++; $display("FAIL b2b hold flags/data got=%b/%h exp=0110/a9", flags, bus.DOut1);
        end
        tick();
        total++;
        if (flags !== 4'b0011) begin
            bad++; $display("FAIL b2b done2 flags got=%b exp=0011", flags);
        end
        tick();
    endtask

    task automatic test_mid_reset();
        bus.src_addr = 4'h0;
        bus.length = 5'd4;
        bus.ready = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        bus.ready = 1'b0;
        total++;
        if (flags !== 4'b1010 || bus.MemAddr !== 4'h1) begin
            bad++; $display("FAIL midrst rd2 flags/addr got=%b/%h exp=1010/1", flags, bus.MemAddr);
        end
        tick();
        tick();
        total++;
        if (flags !== 4'b0110 || bus.DOut1 !== 8'hA3) begin
            bad++; $display("FAIL midrst hold2 flags/data got=%b/%h exp=0110/a3", flags, bus.DOut1);
        end
        reset_n = 1'b0;
        #1;
        total++;
        if (flags !== 4'b0000 || bus.MemAddr !== 4'h0 || bus.DOut1 !== 8'h00) begin
            bad++;
            $display("FAIL midrst async flags/addr/data got=%b/%h/%h exp=0000/0/00",
                     flags, bus.MemAddr, bus.DOut1);
        end
        tick();
        total++;
        if (flags !== 4'b0000) begin
            bad++; $display("FAIL midrst no_done flags got=%b exp=0000", flags);
        end
        reset_n = 1'b1;
        bus.src_addr = 4'h9;
        bus.length = 5'd1;
        bus.ready = 1'b1;
        bus.start = 1'b1;
        tick();
        total++;
        if (flags !== 4'b0000) begin
            bad++; $display("FAIL midrst sync flags got=%b exp=0000", flags);
        end
        tick();
        bus.start = 1'b0;
        total++;
        if (flags !== 4'b1010 || bus.MemAddr !== 4'h9) begin
            bad++; $display("FAIL midrst new_rd flags/addr got=%b/%h exp=1010/9", flags, bus.MemAddr);
        end
        tick();
        tick();
        total++;
        if (flags !== 4'b0110 || bus.DOut1 !== 8'hAB) begin
            bad++; $display("FAIL midrst new_hold flags/data got=%b/%h exp=0110/ab", flags, bus.DOut1);
        end
        tick();
        total++;
        if (flags !== 4'b0011) begin
            bad++; $display("FAIL midrst new_done flags got=%b exp=0011", flags);
        end
        tick();
    endtask

    task automatic test_start_busy();
        logic [3:0] a;
        logic [7:0] d;
        bus.src_addr = 4'h2;
        bus.length = 5'd2;
        bus.ready = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.src_addr = 4'hC; // must not disturb the running transfer
        bus.length = 5'd5;
        for (int w = 0; w < 2; w++) begin
            a = 4'(2 + w);
            d = 8'hA2 + {4'h0, a};
            total++;
            if (flags !== 4'b1010 || bus.MemAddr !== a) begin
                bad++;
                $display("FAIL busy rd%0d flags/addr got=%b/%h exp=1010/%h", w, flags, bus.MemAddr, a);
            end
            tick();
            bus.start = 1'b0;
            tick();
            total++;
            if (flags !== 4'b0110 || bus.DOut1 !== d) begin
                bad++;
                $display("FAIL busy hold%0d flags/data got=%b/%h exp=0110/%h", w, flags, bus.DOut1, d);
            end
            tick();
        end
        total++;
        if (flags !== 4'b0011) begin
            bad++; $display("FAIL busy done flags got=%b exp=0011", flags);
        end
        tick();
        total++;
        if (flags !== 4'b0000) begin
            bad++; $display("FAIL busy idle flags got=%b exp=0000", flags);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_single();
        test_backpressure();
        test_wrap();
        test_zero_length();
        test_back_to_back();
        test_mid_reset();
        test_start_busy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
